// File: rtl/lisp_defs.sv
// Shared definitions for the Lisp heap memory: word constants, ROM image, allocator states.
// No logic of its own; the ROM image is decoded combinationally by rom_word().
package lisp_defs;

  localparam int LISP_DATA_W = 16;
  localparam int LISP_ADDR_W = 12;

  localparam logic [15:0] LISP_NIL = 16'h0000;

  localparam int ROM_WORDS = 5;
  // Element 0 is the rightmost entry: NIL lives at address 0.
  localparam logic [ROM_WORDS-1:0][15:0] ROM_IMAGE =
    {16'h0002, 16'h0001, 16'hDEAD, 16'hBEEF, LISP_NIL};

  typedef enum logic {AL_IDLE, AL_WR1} al_state_t;

  function automatic logic [15:0] rom_word(input logic [31:0] idx);
    logic [15:0] w;
    w = LISP_NIL;
    for (int i = 0; i < ROM_WORDS; i++) begin
      if (idx == 32'(i)) w = ROM_IMAGE[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/heap_ram.sv
// Simple dual-port heap RAM (1R/1W, read-first) with the ROM image overlaid below HEAP_START.
// Read latency 1 cycle; no backpressure, a read and a write are accepted every cycle.
// Out-of-range reads return 0; out-of-range writes are dropped.
module heap_ram import lisp_defs::*; #(
  parameter int DATA_W     = LISP_DATA_W,
  parameter int ADDR_W     = LISP_ADDR_W,
  parameter int DEPTH      = 256,
  parameter int HEAP_START = ROM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < 32'(DEPTH))) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // ROM words are never written, so they are served from the constant image.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (32'(rd_addr) < 32'(HEAP_START))
        rd_data <= DATA_W'(rom_word(32'(rd_addr)));
      else if (32'(rd_addr) < 32'(DEPTH))
        rd_data <= mem[rd_addr[IDX_W-1:0]];
      else
        rd_data <= '0;
    end
  end

endmodule

// File: rtl/lisp_heap_mem.sv
// Lisp heap: registered read port plus bump allocator appending 1 word or a CDR/CAR pair.
// Read latency 1; al_done 1 cycle after accept (single) or 2 cycles (pair).
// al_ready drops for the second cycle of a pair; a request that does not fit is consumed and flags al_err.
module lisp_heap_mem import lisp_defs::*; #(
  parameter int DATA_W     = LISP_DATA_W,
  parameter int ADDR_W     = LISP_ADDR_W,
  parameter int DEPTH      = 256,
  parameter int HEAP_START = ROM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              al_valid,
  input  logic              al_pair,
  input  logic [DATA_W-1:0] al_data0,
  input  logic [DATA_W-1:0] al_data1,
  output logic              al_ready,
  output logic              al_done,
  output logic [ADDR_W-1:0] al_addr,
  output logic              al_err,
  output logic [ADDR_W:0]   free_words
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] START_W = (ADDR_W+1)'(HEAP_START);

  al_state_t         state;
  logic [ADDR_W:0]   heap_ptr;
  logic [DATA_W-1:0] data1_q;
  logic [ADDR_W:0]   need;
  logic              fits;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // One extra bit keeps heap_ptr + need from wrapping at the top of the address space.
  assign need       = al_pair ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign fits       = (heap_ptr + need) <= DEPTH_W;
  assign al_ready   = !rst && (state == AL_IDLE);
  assign free_words = DEPTH_W - heap_ptr;

  assign wr_en   = !rst && (((state == AL_IDLE) && al_valid && fits) || (state == AL_WR1));
  assign wr_addr = (state == AL_WR1) ? al_addr + ADDR_W'(1) : heap_ptr[ADDR_W-1:0];
  assign wr_data = (state == AL_WR1) ? data1_q : al_data0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AL_IDLE;
      heap_ptr <= START_W;
      al_done  <= 1'b0;
      al_addr  <= '0;
      al_err   <= 1'b0;
    end else begin
      al_done <= 1'b0;
      case (state)
        AL_IDLE: begin
          if (al_valid) begin
            if (fits) begin
              al_addr <= heap_ptr[ADDR_W-1:0];
              if (al_pair) begin
                data1_q <= al_data1;
                state   <= AL_WR1;
              end else begin
                heap_ptr <= heap_ptr + (ADDR_W+1)'(1);
                al_done  <= 1'b1;
              end
            end else begin
              al_err <= 1'b1;
            end
          end
        end
        AL_WR1: begin
          heap_ptr <= heap_ptr + (ADDR_W+1)'(2);
          al_done  <= 1'b1;
          state    <= AL_IDLE;
        end
        default: state <= AL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_ready <= 1'b0;
    else     rd_ready <= rd_req;
  end

  heap_ram #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .HEAP_START(HEAP_START)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_lisp_heap_mem.sv
// Bench for lisp_heap_mem: directed scenarios plus random traffic against a word-level heap model.
module tb_lisp_heap_mem;

  localparam int DEPTH = 256;
  localparam int HS    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [11:0] rd_addr = '0;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        al_valid = 1'b0;
  logic        al_pair = 1'b0;
  logic [15:0] al_data0 = '0;
  logic [15:0] al_data1 = '0;
  logic        al_ready;
  logic        al_done;
  logic [11:0] al_addr;
  logic        al_err;
  logic [12:0] free_words;

  always #5 clk = ~clk;

  lisp_heap_mem dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .al_valid(al_valid), .al_pair(al_pair), .al_data0(al_data0), .al_data1(al_data1),
    .al_ready(al_ready), .al_done(al_done), .al_addr(al_addr), .al_err(al_err),
    .free_words(free_words)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Word-level model: the heap is an array that only grows; a pair completes one cycle after acceptance.
  logic [15:0] rom_ref [HS] = '{16'h0000, 16'hBEEF, 16'hDEAD, 16'h0001, 16'h0002};
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_ptr   = HS;
  bit          m_busy  = 0;
  int          m_paddr = 0;
  logic [15:0] m_pd1   = '0;
  bit          m_err   = 0;
  bit          m_live  = 0;
  bit          e_done  = 0;
  int          e_addr  = 0;
  bit          e_rdy   = 0;
  logic [15:0] e_data  = '0;
  bit          e_known = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_ptr = HS; m_busy = 0; m_err = 0;
      e_done = 0; e_addr = 0; e_rdy = 0; e_data = '0; e_known = 1;
    end else begin
      e_rdy = rd_req;
      if (rd_req) begin
        if (int'(rd_addr) >= DEPTH) begin e_data = '0; e_known = 1; end
        else if (int'(rd_addr) < HS) begin e_data = rom_ref[rd_addr]; e_known = 1; end
        else begin e_data = m_mem[rd_addr]; e_known = m_known[rd_addr]; end
      end
      e_done = 0;
      if (m_busy) begin
        m_mem[m_paddr+1] = m_pd1; m_known[m_paddr+1] = 1;
        m_ptr = m_ptr + 2; e_done = 1; e_addr = m_paddr; m_busy = 0;
      end else if (al_valid) begin
        if (m_ptr + (al_pair ? 2 : 1) <= DEPTH) begin
          m_mem[m_ptr] = al_data0; m_known[m_ptr] = 1;
          if (al_pair) begin m_busy = 1; m_paddr = m_ptr; m_pd1 = al_data1; end
          else begin e_done = 1; e_addr = m_ptr; m_ptr = m_ptr + 1; end
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("rd_ready", 32'(rd_ready), 32'(e_rdy));
      if (e_known) check("rd_data", 32'(rd_data), 32'(e_data));
      check("al_ready", 32'(al_ready), 32'(!rst && !m_busy));
      check("al_done", 32'(al_done), 32'(e_done));
      if (e_done) check("al_addr", 32'(al_addr), 32'(e_addr));
      check("al_err", 32'(al_err), 32'(m_err));
      check("free_words", 32'(free_words), 32'(DEPTH - m_ptr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; al_valid = 1'b0; rd_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // 1: reset state and ROM image
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_rd_ready", 32'(rd_ready), 32'h0);
    check("rst_al_err", 32'(al_err), 32'h0);
    check("rst_free", 32'(free_words), 32'd251);
    for (int i = 0; i < HS; i++) begin
      rd_req = 1'b1; rd_addr = 12'(i);
      step();
      check("rom_read", 32'(rd_data), 32'(rom_ref[i]));
    end
    rd_req = 1'b0;

    // 2: single allocation
    al_valid = 1'b1; al_pair = 1'b0; al_data0 = 16'h1234;
    step();
    al_valid = 1'b0;
    check("single_done", 32'(al_done), 32'h1);
    check("single_addr", 32'(al_addr), 32'd5);
    check("single_free", 32'(free_words), 32'd250);
    rd_req = 1'b1; rd_addr = 12'd5;
    step();
    rd_req = 1'b0;
    check("single_read", 32'(rd_data), 32'h1234);

    // 3: pair allocation
    al_valid = 1'b1; al_pair = 1'b1; al_data0 = 16'h0005; al_data1 = 16'h0006;
    step();
    al_valid = 1'b0;
    check("pair_ready_low", 32'(al_ready), 32'h0);
    check("pair_no_done", 32'(al_done), 32'h0);
    step();
    check("pair_done", 32'(al_done), 32'h1);
    check("pair_addr", 32'(al_addr), 32'd6);
    check("pair_free", 32'(free_words), 32'd248);
    rd_req = 1'b1; rd_addr = 12'd6;
    step();
    check("pair_cdr", 32'(rd_data), 32'h0005);
    rd_addr = 12'd7;
    step();
    rd_req = 1'b0;
    check("pair_car", 32'(rd_data), 32'h0006);

    // 4: fill to one free word, then exhaustion
    for (int k = 0; k < 300 && (DEPTH - m_ptr) > 1; k++) begin
      al_valid = 1'b1; al_pair = 1'b0; al_data0 = 16'($urandom);
      rd_req = 1'($urandom); rd_addr = 12'($urandom_range(0, 4095));
      step();
    end
    al_valid = 1'b0; rd_req = 1'b0;
    step();
    check("fill_free", 32'(free_words), 32'd1);
    al_valid = 1'b1; al_pair = 1'b1;
    step();
    check("full_pair_err", 32'(al_err), 32'h1);
    check("full_pair_no_done", 32'(al_done), 32'h0);
    check("full_pair_free", 32'(free_words), 32'd1);
    al_pair = 1'b0; al_data0 = 16'hCAFE;
    step();
    check("last_done", 32'(al_done), 32'h1);
    check("last_addr", 32'(al_addr), 32'd255);
    check("last_free", 32'(free_words), 32'd0);
    step();
    al_valid = 1'b0;
    check("over_err", 32'(al_err), 32'h1);
    check("over_no_done", 32'(al_done), 32'h0);
    rd_req = 1'b1; rd_addr = 12'd255;
    step();
    rd_req = 1'b0;
    check("last_read", 32'(rd_data), 32'hCAFE);

    // 5: read-first collision after reset
    do_reset();
    rd_req = 1'b1; rd_addr = 12'd5;
    al_valid = 1'b1; al_pair = 1'b0; al_data0 = 16'hABCD;
    step();
    al_valid = 1'b0;
    check("collide_old", 32'(rd_data), 32'h1234);
    check("collide_addr", 32'(al_addr), 32'd5);
    step();
    rd_req = 1'b0;
    check("collide_new", 32'(rd_data), 32'hABCD);

    // 6: reset during the second cycle of a pair
    do_reset();
    al_valid = 1'b1; al_pair = 1'b1; al_data0 = 16'h1111; al_data1 = 16'h2222;
    step();
    al_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("wr1_rst_done", 32'(al_done), 32'h0);
    check("wr1_rst_free", 32'(free_words), 32'd251);
    check("wr1_rst_err", 32'(al_err), 32'h0);
    al_valid = 1'b1; al_pair = 1'b0; al_data0 = 16'h3333;
    step();
    al_valid = 1'b0;
    check("after_rst_done", 32'(al_done), 32'h1);
    check("after_rst_addr", 32'(al_addr), 32'd5);

    // random traffic
    for (int k = 0; k < 2500; k++) begin
      rst      = ($urandom_range(0, 399) == 0);
      al_valid = ($urandom_range(0, 2) != 0);
      al_pair  = 1'($urandom);
      al_data0 = 16'($urandom);
      al_data1 = 16'($urandom);
      rd_req   = 1'($urandom);
      rd_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 260));
      step();
    end
    rst = 1'b0; al_valid = 1'b0; rd_req = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
